// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with modulus, load, enable, tc and wrap flags.
// Define UDC_SATURATE_EN to add the sat input (hold at the bound instead of wrapping).
module updown_counter_param #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SATURATE_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    logic             sat_on;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
`ifdef UDC_SATURATE_EN
    assign sat_on = sat;
`else
    assign sat_on = 1'b0;
`endif
    // tc doubles as "next enabled step crosses the bound" in the current direction
    assign tc = mode ? (count == '0) : (count == MAX_VAL);
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load)
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        else if (en && tc) begin
            count_nxt = sat_on ? count : (mode ? MAX_VAL : '0);
            wrap_nxt  = !sat_on;
        end else if (en)
            count_nxt = mode ? count - 1'b1 : count + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed vector table plus hand sequences for updown_counter_param.
module tb_updown_counter_param;
    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic       load;
        logic [7:0] lv;
        int         reps;
        int         c;
        logic       tc;
        logic       wr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, mode, load, sat;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc, wrap;
    logic       rst4, en4, mode4, load4;
    logic [3:0] load_val4, count4;
    logic       tc4, wrap4;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vt[$];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(8), .MAX_VAL(8'd199)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
`ifdef UDC_SATURATE_EN
        .sat(sat),
`endif
        .count(count), .tc(tc), .wrap(wrap)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd15)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .load(load4), .load_val(load_val4),
`ifdef UDC_SATURATE_EN
        .sat(1'b0),
`endif
        .count(count4), .tc(tc4), .wrap(wrap4)
    );

    function automatic vec_t mk(logic r, logic e, logic m, logic l, int lv, int reps,
                                int c, logic t, logic w);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.load = l; v.lv = 8'(lv);
        v.reps = reps; v.c = c; v.tc = t; v.wr = w;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input logic l, input int lv);
        rst = r; en = e; mode = m; load = l; load_val = 8'(lv);
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string name, input int c, input logic t, input logic w);
        chk({name, " count"}, int'(count), c);
        chk({name, " tc"}, int'(tc), int'(t));
        chk({name, " wrap"}, int'(wrap), int'(w));
    endtask

    initial begin
        sat = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 50);
        rst4 = 1'b0; en4 = 1'b0; mode4 = 1'b0; load4 = 1'b0; load_val4 = 4'd0;

        // reset dominates load and en
        for (int i = 0; i < 2; i++) begin
            edge1();
            chk3($sformatf("reset%0d", i), 0, 1'b1, 1'b0);
        end

        // full up sweep through the non-power-of-2 wrap
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 205; i++) begin
            edge1();
            if (i == 199) chk3("up199", 199, 1'b1, 1'b0);
            if (i == 200) chk3("up200", 0, 1'b0, 1'b1);
            if (i == 201) chk3("up201", 1, 1'b0, 1'b0);
            if (i == 205) chk3("up205", 5, 1'b0, 1'b0);
        end

        vt.push_back(mk(1, 0, 0, 1, 250, 1, 199, 1, 0));
        vt.push_back(mk(1, 1, 0, 1,   7, 1,   7, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 200, 1, 199, 1, 0));
        vt.push_back(mk(1, 0, 0, 1, 199, 1, 199, 1, 0));
        vt.push_back(mk(1, 1, 1, 1,   2, 1,   2, 0, 0));
        vt.push_back(mk(1, 1, 1, 0,   0, 1,   1, 0, 0));
        vt.push_back(mk(1, 1, 1, 0,   0, 1,   0, 1, 0));
        vt.push_back(mk(1, 1, 1, 0,   0, 1, 199, 0, 1));
        vt.push_back(mk(1, 1, 1, 0,   0, 1, 198, 0, 0));
        vt.push_back(mk(1, 1, 0, 0,   0, 1, 199, 1, 0));
        vt.push_back(mk(1, 1, 0, 0,   0, 1,   0, 0, 1));
        vt.push_back(mk(1, 1, 1, 0,   0, 1, 199, 0, 1));
        vt.push_back(mk(1, 1, 0, 0,   0, 1,   0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0,   0, 1,   0, 1, 0));
        vt.push_back(mk(1, 0, 0, 1,  42, 1,  42, 0, 0));
        vt.push_back(mk(1, 0, 0, 0,   0, 10, 42, 0, 0));
        vt.push_back(mk(1, 0, 0, 1, 120, 1, 120, 0, 0));
        vt.push_back(mk(1, 1, 0, 0,   0, 1, 121, 0, 0));
        vt.push_back(mk(0, 1, 1, 0,   0, 1,   0, 1, 0));
        vt.push_back(mk(1, 1, 0, 0,   0, 1,   1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0,   0, 1,   2, 0, 0));

        foreach (vt[k]) begin
            drive(vt[k].rst, vt[k].en, vt[k].mode, vt[k].load, int'(vt[k].lv));
            for (int r = 0; r < vt[k].reps; r++) begin
                edge1();
                chk3($sformatf("vec%0d.%0d", k, r), vt[k].c, vt[k].tc, vt[k].wr);
            end
        end

`ifdef UDC_SATURATE_EN
        sat = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 198);
        edge1();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        edge1(); chk3("sat_up0", 199, 1'b1, 1'b0);
        edge1(); chk3("sat_up1", 199, 1'b1, 1'b0);
        edge1(); chk3("sat_up2", 199, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1);
        edge1();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        edge1(); chk3("sat_dn0", 0, 1'b1, 1'b0);
        edge1(); chk3("sat_dn1", 0, 1'b1, 1'b0);
        sat = 1'b0;
        edge1(); chk3("sat_off_wrap", 199, 1'b0, 1'b1);
`endif

        // power-of-2 modulus on the narrow instance
        edge1();
        chk("w4 reset", int'(count4), 0);
        rst4 = 1'b1; load4 = 1'b1; load_val4 = 4'd14;
        edge1(); chk("w4 load14", int'(count4), 14);
        load4 = 1'b0; en4 = 1'b1;
        edge1(); chk("w4 15", int'(count4), 15); chk("w4 tc15", int'(tc4), 1);
        edge1(); chk("w4 wrap0", int'(count4), 0); chk("w4 wrap0 flag", int'(wrap4), 1);
        edge1(); chk("w4 1", int'(count4), 1); chk("w4 wrap clr", int'(wrap4), 0);
        mode4 = 1'b1;
        edge1(); chk("w4 dn0", int'(count4), 0); chk("w4 tc0", int'(tc4), 1);
        edge1(); chk("w4 dn15", int'(count4), 15); chk("w4 dn wrap", int'(wrap4), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
